in_service_control_8259: RTL and testbench

IN_SERVICE_CONTROL_8259 -- requirements
Module: in_service_control_8259

---
 rtl/pic_8259_pkg.sv | 34 +++
 rtl/isr_priority_find_8259.sv | 24 ++
 rtl/in_service_control_8259.sv | 133 +++++++++++++
 tb/tb_in_service_control_8259.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_8259_pkg.sv
// Shared types, OCW2 command codes and level/one-hot helpers for the 8259 in-service logic.
package pic_8259_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
    } ack_state_e;

    // OCW2 R/SL/EOI field encodings
    localparam logic [2:0] OCW2_CLR_RAEOI  = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
    localparam logic [2:0] OCW2_NOP        = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI     = 3'b011;
    localparam logic [2:0] OCW2_SET_RAEOI  = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO   = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI = 3'b111;

    function automatic logic [7:0] level2onehot(input logic [2:0] lvl);
        return 8'b1 << lvl;
    endfunction

    // Lowest set bit wins if more than one is set.
    function automatic logic [2:0] onehot2level(input logic [7:0] oh);
        logic [2:0] lvl;
        lvl = '0;
        for (int i = 7; i >= 0; i--) begin
            if (oh[i]) lvl = 3'(i);
        end
        return lvl;
    endfunction

endpackage

// File: rtl/isr_priority_find_8259.sv
// Finds the highest-priority in-service level, starting just above the lowest-priority level.
module isr_priority_find_8259 import pic_8259_pkg::*; (
    input  logic [7:0] isr,
    input  logic [2:0] priority_rotate,
    output logic [7:0] highest
);

    logic [2:0] lvl;
    logic       found;

    always_comb begin
        highest = '0;
        found   = 1'b0;
        lvl     = '0;
        for (int i = 1; i <= 8; i++) begin
            lvl = priority_rotate + 3'(i);
            if (!found && isr[lvl]) begin
                highest = level2onehot(lvl);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/in_service_control_8259.sv
// 8259 in-service register, INTA acknowledge sequencer, EOI/rotation handling and vector drive.
module in_service_control_8259 import pic_8259_pkg::*; (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] interrupt,
    input  logic       inta_n,
    input  logic       eoi_valid,
    input  logic [2:0] eoi_cmd,
    input  logic [2:0] eoi_level,
    input  logic       auto_eoi,
    input  logic [4:0] vector_base,
    output logic       int_out,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic [2:0] priority_rotate,
    output logic [7:0] clear_request,
    output logic [7:0] data_out,
    output logic       data_out_en
);

    ack_state_e state_q, state_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] rot_q, rot_d;
    logic       raeoi_q, raeoi_d;
    logic [2:0] ack_level_q, ack_level_d;
    logic [7:0] clr_req_q, clr_req_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_out_en_q, data_out_en_d;
    logic       inta_q;

    logic       inta_fall, inta_rise;
    logic [7:0] set_mask, clr_mask;
    logic [7:0] hlis;

    isr_priority_find_8259 u_find (
        .isr             (isr_q),
        .priority_rotate (rot_q),
        .highest         (hlis)
    );

    assign inta_fall = inta_q & ~inta_n;
    assign inta_rise = ~inta_q & inta_n;

    always_comb begin
        state_d     = state_q;
        ack_level_d = ack_level_q;
        rot_d       = rot_q;
        raeoi_d     = raeoi_q;
        set_mask    = '0;
        clr_mask    = '0;
        clr_req_d   = '0;

        case (state_q)
            ST_IDLE: if (inta_fall) begin
                state_d = ST_ACK1;
                if (|interrupt) begin
                    ack_level_d = onehot2level(interrupt);
                    set_mask    = level2onehot(ack_level_d);
                    clr_req_d   = set_mask;
                end else begin
                    ack_level_d = 3'd7;
                end
            end
            ST_ACK1: if (inta_fall) state_d = ST_ACK2;
            ST_ACK2: if (inta_rise) begin
                state_d = ST_IDLE;
                if (auto_eoi) begin
                    clr_mask = level2onehot(ack_level_q);
                    if (raeoi_q) rot_d = ack_level_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An explicit OCW2 rotation overrides an AEOI rotation in the same cycle.
        if (eoi_valid) begin
            case (eoi_cmd)
                OCW2_NS_EOI:     clr_mask = clr_mask | hlis;
                OCW2_SP_EOI:     clr_mask = clr_mask | level2onehot(eoi_level);
                OCW2_ROT_NS_EOI: if (|hlis) begin
                    clr_mask = clr_mask | hlis;
                    rot_d    = onehot2level(hlis);
                end
                OCW2_ROT_SP_EOI: begin
                    clr_mask = clr_mask | level2onehot(eoi_level);
                    rot_d    = eoi_level;
                end
                OCW2_SET_PRIO:   rot_d   = eoi_level;
                OCW2_SET_RAEOI:  raeoi_d = 1'b1;
                OCW2_CLR_RAEOI:  raeoi_d = 1'b0;
                default: ;
            endcase
        end

        // Set after clear so an acknowledge beats a same-cycle EOI on its own bit.
        isr_d         = (isr_q & ~clr_mask) | set_mask;
        data_out_en_d = (state_d == ST_ACK2) && !inta_n;
        data_out_d    = data_out_en_d ? {vector_base, ack_level_d} : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            isr_q         <= '0;
            rot_q         <= 3'b111;
            raeoi_q       <= 1'b0;
            ack_level_q   <= '0;
            clr_req_q     <= '0;
            data_out_q    <= '0;
            data_out_en_q <= 1'b0;
            inta_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            isr_q         <= isr_d;
            rot_q         <= rot_d;
            raeoi_q       <= raeoi_d;
            ack_level_q   <= ack_level_d;
            clr_req_q     <= clr_req_d;
            data_out_q    <= data_out_d;
            data_out_en_q <= data_out_en_d;
            inta_q        <= inta_n;
        end
    end

    assign int_out                  = (state_q == ST_IDLE) && (|interrupt);
    assign in_service_register      = isr_q;
    assign highest_level_in_service = hlis;
    assign priority_rotate          = rot_q;
    assign clear_request            = clr_req_q;
    assign data_out                 = data_out_q;
    assign data_out_en              = data_out_en_q;

endmodule

// File: tb/tb_in_service_control_8259.sv
// Scoreboard bench for in_service_control_8259: directed scenarios plus random ack/EOI traffic.
module tb_in_service_control_8259;

    logic       clk;
    logic       reset_n;
    logic [7:0] interrupt;
    logic       inta_n;
    logic       eoi_valid;
    logic [2:0] eoi_cmd;
    logic [2:0] eoi_level;
    logic       auto_eoi;
    logic [4:0] vector_base;
    logic       int_out;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic [2:0] priority_rotate;
    logic [7:0] clear_request;
    logic [7:0] data_out;
    logic       data_out_en;

    in_service_control_8259 dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .interrupt                (interrupt),
        .inta_n                   (inta_n),
        .eoi_valid                (eoi_valid),
        .eoi_cmd                  (eoi_cmd),
        .eoi_level                (eoi_level),
        .auto_eoi                 (auto_eoi),
        .vector_base              (vector_base),
        .int_out                  (int_out),
        .in_service_register      (in_service_register),
        .highest_level_in_service (highest_level_in_service),
        .priority_rotate          (priority_rotate),
        .clear_request            (clear_request),
        .data_out                 (data_out),
        .data_out_en              (data_out_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] vec_q[$];
    logic [7:0] clr_q[$];

    // Reference model: ISR as an array of flags, rotation as a plain integer.
    int m_isr[8];
    int m_rot;
    int m_raeoi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int m_highest();
        for (int k = 1; k <= 8; k++) begin
            if (m_isr[(m_rot + k) % 8] != 0) return (m_rot + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] m_isr_byte();
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) if (m_isr[i] != 0) b = b | (8'h01 << i);
        return b;
    endfunction

    function automatic int lowest_bit(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 7;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_isr[i] = 0;
        m_rot   = 7;
        m_raeoi = 0;
    endtask

    task automatic model_eoi(input int cmd, input int lvl);
        int h;
        h = m_highest();
        case (cmd)
            1: if (h >= 0) m_isr[h] = 0;
            3: m_isr[lvl] = 0;
            5: if (h >= 0) begin m_isr[h] = 0; m_rot = h; end
            7: begin m_isr[lvl] = 0; m_rot = lvl; end
            6: m_rot = lvl;
            4: m_raeoi = 1;
            0: m_raeoi = 0;
            default: ;
        endcase
    endtask

    task automatic chk_state(input string tag);
        int h;
        h = m_highest();
        chk({tag, "_isr"}, 32'(in_service_register), 32'(m_isr_byte()));
        chk({tag, "_rot"}, 32'(priority_rotate), 32'(m_rot));
        chk({tag, "_hlis"}, 32'(highest_level_in_service), (h >= 0) ? (32'h1 << h) : 32'h0);
    endtask

    // Monitor: every vector-drive onset and every clear_request pulse must match a queued expectation.
    initial begin
        logic en_prev;
        en_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (data_out_en && !en_prev) begin
                if (vec_q.size() == 0) chk("unexpected_vector", 32'(data_out), 32'h1ff);
                else chk("vector", 32'(data_out), 32'(vec_q.pop_front()));
            end
            en_prev = data_out_en;
            if (clear_request != 8'h00) begin
                if (clr_q.size() == 0) chk("unexpected_clear", 32'(clear_request), 32'h0);
                else chk("clear_request", 32'(clear_request), 32'(clr_q.pop_front()));
            end
        end
    end

    task automatic do_ack(input logic [7:0] irq, input bit sim,
                          input logic [2:0] scmd, input logic [2:0] slvl);
        int lvl;
        @(negedge clk);
        interrupt = irq;
        #1 chk("int_out_idle", 32'(int_out), 32'(|irq));
        lvl = (irq == 8'h00) ? 7 : lowest_bit(irq);
        if (irq != 8'h00) clr_q.push_back(irq);
        vec_q.push_back({vector_base, 3'(lvl)});
        @(negedge clk);
        inta_n = 1'b0;
        if (sim) begin
            eoi_valid = 1'b1;
            eoi_cmd   = scmd;
            eoi_level = slvl;
            model_eoi(int'(scmd), int'(slvl));
        end
        if (irq != 8'h00) m_isr[lvl] = 1;
        @(negedge clk);
        eoi_valid = 1'b0;
        if (irq != 8'h00) chk("int_out_in_ack", 32'(int_out), 32'h0);
        interrupt = 8'h00;
        @(negedge clk);
        inta_n = 1'b1;
        repeat (2) @(negedge clk);
        inta_n = 1'b0;
        repeat (3) @(negedge clk);
        inta_n = 1'b1;
        if (auto_eoi) begin
            m_isr[lvl] = 0;
            if (m_raeoi != 0) m_rot = lvl;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("data_out_en_after", 32'(data_out_en), 32'h0);
        chk_state("ack");
    endtask

    task automatic do_eoi(input logic [2:0] cmd, input logic [2:0] lvl);
        @(negedge clk);
        eoi_valid = 1'b1;
        eoi_cmd   = cmd;
        eoi_level = lvl;
        model_eoi(int'(cmd), int'(lvl));
        @(negedge clk);
        eoi_valid = 1'b0;
        #1 chk_state("eoi");
    endtask

    initial begin
        reset_n     = 1'b0;
        interrupt   = 8'h00;
        inta_n      = 1'b1;
        eoi_valid   = 1'b0;
        eoi_cmd     = 3'b010;
        eoi_level   = 3'd0;
        auto_eoi    = 1'b0;
        vector_base = 5'h08;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_state("reset");
        chk("reset_clear_request", 32'(clear_request), 32'h0);
        chk("reset_data_out", 32'(data_out), 32'h0);
        chk("reset_data_out_en", 32'(data_out_en), 32'h0);

        // Level 2 acknowledged with base 0x08 gives vector 0x42.
        do_ack(8'h04, 1'b0, 3'b010, 3'd0);

        // Build ISR = 0x0A, then non-specific and rotating non-specific EOIs.
        do_eoi(3'b001, 3'd0);
        do_ack(8'h02, 1'b0, 3'b010, 3'd0);
        do_ack(8'h08, 1'b0, 3'b010, 3'd0);
        chk("isr_0a", 32'(in_service_register), 32'h0a);
        do_eoi(3'b001, 3'd0);
        do_eoi(3'b101, 3'd0);
        do_eoi(3'b001, 3'd4);

        // Spurious acknowledge.
        vector_base = 5'h11;
        do_ack(8'h00, 1'b0, 3'b010, 3'd0);

        // AEOI with rotation.
        do_eoi(3'b100, 3'd0);
        auto_eoi = 1'b1;
        do_ack(8'h20, 1'b0, 3'b010, 3'd0);
        auto_eoi = 1'b0;
        do_eoi(3'b000, 3'd0);

        // Ack set and specific EOI on the same bit in one cycle.
        do_ack(8'h04, 1'b1, 3'b011, 3'd2);

        // Reset while in ACK1.
        @(negedge clk);
        interrupt = 8'h10;
        inta_n    = 1'b0;
        clr_q.push_back(8'h10);
        @(negedge clk);
        interrupt = 8'h00;
        @(negedge clk);
        reset_n = 1'b0;
        inta_n  = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        #1;
        chk_state("mid_ack_reset");
        chk("mid_ack_reset_en", 32'(data_out_en), 32'h0);
        interrupt = 8'h10;
        #1 chk("mid_ack_reset_idle", 32'(int_out), 32'h1);
        repeat (4) @(negedge clk);
        #1 chk("no_vector_after_reset", 32'(data_out_en), 32'h0);
        interrupt = 8'h00;

        // Random traffic.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                logic [7:0] irq;
                irq         = ($urandom_range(7, 0) == 0) ? 8'h00 : (8'h01 << $urandom_range(7, 0));
                auto_eoi    = 1'($urandom_range(1, 0));
                vector_base = 5'($urandom);
                do_ack(irq, 1'b0, 3'b010, 3'd0);
            end else begin
                do_eoi(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
            end
        end

        repeat (3) @(negedge clk);
        chk("vectors_outstanding", 32'(vec_q.size()), 32'h0);
        chk("clears_outstanding", 32'(clr_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
